// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared state encoding and frame constants for the frame sender
package uart_frame_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_END} state_t;
  localparam logic [7:0] DEF_HEADER = 8'hA5;
  localparam int CSUM_W = 8;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  // shift the async input through two flops, both cleared on reset
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_frame_sender.sv
// uart_frame_sender: sends header, N buffered bytes and a checksum to a UART via ready/status handshake
module uart_frame_sender
  import uart_frame_pkg::*;
#(
  parameter int N_BYTES = 9,
  parameter logic [7:0] HEADER = DEF_HEADER,
  parameter int TIMEOUT_CYC = 262144,
  localparam int AW = N_BYTES > 1 ? $clog2(N_BYTES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          buf_we,
  input  logic [AW-1:0] buf_addr,
  input  logic [7:0]    buf_wdata,
  input  logic          tx_status,
  output logic          tx_ready,
  output logic [7:0]    tx_byte,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam int IW = $clog2(N_BYTES + 2);
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [IW-1:0] LAST = IW'(N_BYTES + 1);
  localparam logic [IW-1:0] NB = IW'(N_BYTES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
  logic [7:0] mem [N_BYTES];
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [CSUM_W-1:0] csum, csum_n;
  logic [CW-1:0] wcnt, wcnt_n;
  logic [7:0] byte_n, nxt;
  logic rdy_n, busy_n, done_n, err_n, st_s;
  sync_2ff u_sync (.clk(clk), .rst(rst), .d(tx_status), .q(st_s));
  // payload buffer; frozen while a frame is in flight, out-of-range addresses dropped
  always_ff @(posedge clk)
    if (buf_we && !busy && int'(buf_addr) < N_BYTES) mem[buf_addr] <= buf_wdata;
  assign nxt = mem[idx[AW-1:0]];
  // handshake sequencer: next state and next values of every registered output
  always_comb begin
    state_n = state;
    idx_n = idx;
    csum_n = csum;
    byte_n = tx_byte;
    rdy_n = tx_ready;
    busy_n = busy;
    done_n = 1'b0;
    err_n = err;
    wcnt_n = wcnt + 1'b1;
    if (state != IDLE && wcnt == TO_LAST) begin
      err_n = 1'b1;
      rdy_n = 1'b0;
      busy_n = 1'b0;
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          wcnt_n = '0;
          rdy_n = start;
          if (start) begin
            byte_n = HEADER;
            busy_n = 1'b1;
            idx_n = '0;
            err_n = 1'b0;
            csum_n = '0;
            state_n = REQ;
          end
        end
        REQ:
          if (st_s) begin
            rdy_n = 1'b0;
            wcnt_n = '0;
            state_n = WAIT_END;
          end
        WAIT_END:
          if (!st_s) begin
            wcnt_n = '0;
            if (idx == LAST) begin
              busy_n = 1'b0;
              done_n = 1'b1;
              state_n = IDLE;
            end else begin
              idx_n = idx + 1'b1;
              byte_n = idx < NB ? nxt : csum;
              csum_n = idx < NB ? csum + nxt : csum;
              rdy_n = 1'b1;
              state_n = REQ;
            end
          end
        default: state_n = IDLE;
      endcase
    end
  end
  // state and output registers, all cleared asynchronously
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      csum <= '0;
      wcnt <= '0;
      tx_byte <= '0;
      tx_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      csum <= csum_n;
      wcnt <= wcnt_n;
      tx_byte <= byte_n;
      tx_ready <= rdy_n;
      busy <= busy_n;
      done <= done_n;
      err <= err_n;
    end
endmodule
